// File: rtl/clock_pkg.sv
// Shared encodings for the clock front panel: cursor positions,
// screen ids, edit FSM and per-key auto-repeat FSM states.
package clock_pkg;

    localparam logic [2:0] POS_HR_T  = 3'd0;
    localparam logic [2:0] POS_HR_U  = 3'd1;
    localparam logic [2:0] POS_MIN_T = 3'd2;
    localparam logic [2:0] POS_MIN_U = 3'd3;
    localparam logic [2:0] POS_SEC_T = 3'd4;
    localparam logic [2:0] POS_SEC_U = 3'd5;

    localparam logic [1:0] SCR_TIME  = 2'd0;
    localparam logic [1:0] SCR_DATE  = 2'd1;
    localparam logic [1:0] SCR_ALARM = 2'd2;
    localparam logic [1:0] SCR_STOPW = 2'd3;

    typedef enum logic {
        VIEW = 1'b0,
        EDIT = 1'b1
    } edit_state_t;

    typedef enum logic [1:0] {
        REL  = 2'd0,
        HELD = 2'd1,
        RPT  = 2'd2
    } rpt_state_t;

    function automatic logic [1:0] next_screen(input logic [1:0] s,
                                               input int n);
        return (int'(s) >= n - 1) ? SCR_TIME : s + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low button -> 2-FF sync -> debounced level + press pulse.
// Ports: clk, reset (async low), btn (raw), held (debounced pressed), press (1-cycle).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic held,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;
    logic          accept;

    // The new level is taken on the edge where it has been seen
    // for DEBOUNCE_CYC consecutive synchronised samples.
    assign accept = (s2 != lvl) && (cnt == CNT_LAST);
    assign press  = accept & ~s2;
    assign held   = ~lvl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            lvl <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (accept) begin
                lvl <= s2;
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edit_key_controller.sv
// Front-panel controller: debounced buttons, VIEW/EDIT FSM, cursor,
// screen select, edit timeout, and Plus/Minus strobes with auto-repeat.
// Ports: clk, reset (async low), ClkSecond tick, BtnScreen/BtnEdit/BtnPlus/BtnMinus
// (raw, active-low) -> EditMode, EditPos, screen, KeyPlus/KeyMinus (active-low), Blink.
module edit_key_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter int TIMEOUT_S    = 30,
    parameter int NUM_POS      = 6,
    parameter int NUM_SCREENS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ClkSecond,
    input  logic       BtnScreen,
    input  logic       BtnEdit,
    input  logic       BtnPlus,
    input  logic       BtnMinus,
    output logic       EditMode,
    output logic [2:0] EditPos,
    output logic [1:0] screen,
    output logic       KeyPlus,
    output logic       KeyMinus,
    output logic       Blink
);

    localparam int TW   = $clog2(TIMEOUT_S) + 1;
    localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_S - 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYC - 1);
    localparam logic [2:0]    POS_LAST  = 3'(NUM_POS - 1);

    // Key index: 0 screen, 1 edit, 2 plus, 3 minus
    logic [3:0] raw_n;
    logic [3:0] held;
    logic [3:0] press;

    assign raw_n = {BtnMinus, BtnPlus, BtnEdit, BtnScreen};

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key[3:0] (
        .clk  (clk),
        .reset(reset),
        .btn  (raw_n),
        .held (held),
        .press(press)
    );

    edit_state_t   state;
    rpt_state_t    rpt_st[2];
    logic [RW-1:0] rcnt[2];
    logic [TW-1:0] tcnt;
    logic          lock;
    logic [1:0]    key_n;

    logic any_press;
    logic both_now;
    logic lock_eff;
    logic expire;
    logic unused;

    assign any_press = |press;
    assign both_now  = (held[2] | press[2]) & (held[3] | press[3]);
    // Once both keys were down, stay silent until both are up again.
    assign lock_eff  = lock | both_now;
    // A press on the expiry tick restarts the timeout instead.
    assign expire    = ClkSecond & ~any_press & (tcnt == TO_LAST);
    assign unused    = ^held[1:0];

    assign EditMode = (state == EDIT);
    assign KeyPlus  = key_n[0];
    assign KeyMinus = key_n[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= VIEW;
            EditPos <= POS_HR_T;
            screen  <= SCR_TIME;
            Blink   <= 1'b0;
            tcnt    <= '0;
            lock    <= 1'b0;
            key_n   <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                rpt_st[k] <= REL;
                rcnt[k]   <= '0;
            end
        end else begin
            key_n <= 2'b11;
            lock  <= both_now | (lock & (held[2] | held[3]));
            case (state)
                VIEW: begin
                    Blink <= 1'b0;
                    tcnt  <= '0;
                    for (int k = 0; k < 2; k++) begin
                        rpt_st[k] <= REL;
                        rcnt[k]   <= '0;
                    end
                    if (press[1]) begin
                        state   <= EDIT;
                        EditPos <= POS_HR_T;
                    end else if (press[0]) begin
                        screen <= next_screen(screen, NUM_SCREENS);
                    end
                end
                EDIT: begin
                    if ((press[1] && EditPos == POS_LAST) || expire) begin
                        state   <= VIEW;
                        EditPos <= POS_HR_T;
                        Blink   <= 1'b0;
                        tcnt    <= '0;
                        for (int k = 0; k < 2; k++) begin
                            rpt_st[k] <= REL;
                            rcnt[k]   <= '0;
                        end
                    end else begin
                        if (press[1])
                            EditPos <= EditPos + 3'd1;
                        if (any_press)
                            tcnt <= '0;
                        else if (ClkSecond && tcnt != '1)
                            tcnt <= tcnt + 1'b1;
                        if (ClkSecond)
                            Blink <= ~Blink;
                        // An edit press in the same cycle drops the strobe.
                        for (int k = 0; k < 2; k++) begin
                            if (lock_eff) begin
                                rpt_st[k] <= REL;
                                rcnt[k]   <= '0;
                            end else begin
                                case (rpt_st[k])
                                    REL: begin
                                        if (press[k+2] && !press[1]) begin
                                            rpt_st[k] <= HELD;
                                            rcnt[k]   <= '0;
                                            key_n[k]  <= 1'b0;
                                        end
                                    end
                                    HELD: begin
                                        if (!held[k+2]) begin
                                            rpt_st[k] <= REL;
                                        end else if (rcnt[k] == HOLD_LAST) begin
                                            rpt_st[k] <= RPT;
                                            rcnt[k]   <= '0;
                                            if (!press[1])
                                                key_n[k] <= 1'b0;
                                        end else begin
                                            rcnt[k] <= rcnt[k] + 1'b1;
                                        end
                                    end
                                    RPT: begin
                                        if (!held[k+2]) begin
                                            rpt_st[k] <= REL;
                                        end else if (rcnt[k] == RPT_LAST) begin
                                            rcnt[k] <= '0;
                                            if (!press[1])
                                                key_n[k] <= 1'b0;
                                        end else begin
                                            rcnt[k] <= rcnt[k] + 1'b1;
                                        end
                                    end
                                    default: rpt_st[k] <= REL;
                                endcase
                            end
                        end
                    end
                end
                default: state <= VIEW;
            endcase
        end
    end

endmodule

// File: tb/tb_edit_key_controller.sv
// Bench for edit_key_controller with short timing parameters:
// table-driven navigation, hand-written corner sequences, random vs model.
module tb_edit_key_controller;

    localparam int D    = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int TO   = 3;
    localparam int NPOS = 6;
    localparam int NSCR = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ClkSecond = 1'b0;
    logic       BtnScreen = 1'b1;
    logic       BtnEdit = 1'b1;
    logic       BtnPlus = 1'b1;
    logic       BtnMinus = 1'b1;
    logic       EditMode;
    logic [2:0] EditPos;
    logic [1:0] screen;
    logic       KeyPlus;
    logic       KeyMinus;
    logic       Blink;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edit_key_controller #(
        .DEBOUNCE_CYC(D),
        .HOLD_CYC    (HOLD),
        .REPEAT_CYC  (REP),
        .TIMEOUT_S   (TO),
        .NUM_POS     (NPOS),
        .NUM_SCREENS (NSCR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ClkSecond(ClkSecond),
        .BtnScreen(BtnScreen),
        .BtnEdit  (BtnEdit),
        .BtnPlus  (BtnPlus),
        .BtnMinus (BtnMinus),
        .EditMode (EditMode),
        .EditPos  (EditPos),
        .screen   (screen),
        .KeyPlus  (KeyPlus),
        .KeyMinus (KeyMinus),
        .Blink    (Blink)
    );

    typedef struct {
        int btn;
        int hold;
        int mode;
        int pos;
        int scr;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: BtnScreen = v;
            1: BtnEdit = v;
            2: BtnPlus = v;
            default: BtnMinus = v;
        endcase
    endtask

    task automatic tap(input int b, input int hold, input int gap);
        set_btn(b, 1'b0);
        repeat (hold) step();
        set_btn(b, 1'b1);
        repeat (gap) step();
    endtask

    task automatic tick();
        ClkSecond = 1'b1;
        step();
        ClkSecond = 1'b0;
    endtask

    task automatic count_lows(input int n, output int lp, output int lm);
        lp = 0;
        lm = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (KeyPlus === 1'b0) lp++;
            if (KeyMinus === 1'b0) lm++;
        end
    endtask

    // Reference model state
    logic [15:0] hist[4];
    logic        lvl[4];
    logic        pr[4];
    logic        hb[4];
    logic        medit;
    int          mpos;
    int          mscr;
    int          mto;
    logic        mblink;
    logic        seq_on;
    int          t0;
    int          n_edge;
    logic        kp;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            hist[b] = '1;
            lvl[b]  = 1'b1;
        end
        medit  = 1'b0;
        mpos   = 0;
        mscr   = 0;
        mto    = 0;
        mblink = 1'b0;
        seq_on = 1'b0;
        t0     = 0;
        n_edge = 0;
    endtask

    // One clock edge: a level is accepted once the last D synchronised
    // samples (raw delayed by two flops) all disagree with it.
    task automatic model_edge(input logic [3:0] raw, input logic tk);
        logic leave;
        n_edge++;
        for (int b = 0; b < 4; b++) begin
            hb[b]   = ~lvl[b];
            hist[b] = {hist[b][14:0], raw[b]};
            pr[b]   = 1'b0;
            if (lvl[b] && ~|hist[b][D+1:2]) begin
                lvl[b] = 1'b0;
                pr[b]  = 1'b1;
            end else if (!lvl[b] && &hist[b][D+1:2]) begin
                lvl[b] = 1'b1;
            end
        end
        kp = 1'b1;
        if (!medit) begin
            mblink = 1'b0;
            seq_on = 1'b0;
            if (pr[1]) begin
                medit = 1'b1;
                mpos  = 0;
                mto   = 0;
            end else if (pr[0]) begin
                mscr = (mscr + 1) % NSCR;
            end
        end else begin
            leave = 1'b0;
            if (pr[1]) begin
                if (mpos == NPOS - 1) leave = 1'b1;
                else mpos++;
            end
            if (pr[0] | pr[1] | pr[2] | pr[3]) mto = 0;
            else mto += int'(tk);
            if (mto >= TO) leave = 1'b1;
            if (leave) begin
                medit  = 1'b0;
                mpos   = 0;
                mblink = 1'b0;
                seq_on = 1'b0;
                mto    = 0;
            end else begin
                mblink = mblink ^ tk;
                if (pr[2]) begin
                    if (!pr[1]) begin
                        seq_on = 1'b1;
                        t0     = n_edge;
                        kp     = 1'b0;
                    end
                end else if (seq_on) begin
                    if (!hb[2]) begin
                        seq_on = 1'b0;
                    end else if (n_edge - t0 >= HOLD &&
                                 (n_edge - t0 - HOLD) % REP == 0 &&
                                 !pr[1]) begin
                        kp = 1'b0;
                    end
                end
            end
        end
    endtask

    vec_t tbl[16];
    int   exp4[6];

    initial begin
        int lows[$];
        int lp;
        int lm;
        int runl[3];
        int maxr[3];
        logic [3:0] rawv;
        logic tk;
        logic [8:0] act;
        logic [8:0] exp;

        tbl[0]  = '{0, 8, 0, 0, 1};
        tbl[1]  = '{0, 2, 0, 0, 1};
        tbl[2]  = '{0, 8, 0, 0, 2};
        tbl[3]  = '{0, 2, 0, 0, 2};
        tbl[4]  = '{0, 8, 0, 0, 3};
        tbl[5]  = '{0, 8, 0, 0, 0};
        tbl[6]  = '{0, 8, 0, 0, 1};
        tbl[7]  = '{1, 8, 1, 0, 1};
        tbl[8]  = '{1, 2, 1, 0, 1};
        tbl[9]  = '{1, 8, 1, 1, 1};
        tbl[10] = '{0, 8, 1, 1, 1};
        tbl[11] = '{1, 8, 1, 2, 1};
        tbl[12] = '{1, 8, 1, 3, 1};
        tbl[13] = '{1, 8, 1, 4, 1};
        tbl[14] = '{1, 8, 1, 5, 1};
        tbl[15] = '{1, 8, 0, 0, 1};
        exp4 = '{6, 26, 34, 42, 50, 58};

        // Asynchronous reset, no clock edge yet
        #1 reset = 1'b0;
        #1;
        chk("rst_mode", EditMode, 0);
        chk("rst_pos", EditPos, 0);
        chk("rst_scr", screen, 0);
        chk("rst_keys", {KeyPlus, KeyMinus}, 2'b11);
        chk("rst_blink", Blink, 0);
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();

        // Screen cycling with glitches, edit cursor walk
        for (int i = 0; i < 16; i++) begin
            tap(tbl[i].btn, tbl[i].hold, 12);
            chk($sformatf("tbl%0d_mode", i), EditMode, tbl[i].mode);
            chk($sformatf("tbl%0d_pos", i), EditPos, tbl[i].pos);
            chk($sformatf("tbl%0d_scr", i), screen, tbl[i].scr);
        end

        // Plus held 60 cycles in EDIT: first strobe then auto-repeat
        tap(1, 8, 12);
        chk("t4_edit", EditMode, 1);
        BtnPlus = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (KeyPlus === 1'b0) lows.push_back(c);
        end
        BtnPlus = 1'b1;
        repeat (12) step();
        chk("t4_count", lows.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4_strobe%0d", i),
                (i < lows.size()) ? lows[i] : -1, exp4[i]);

        // Plus+Minus together, Minus released first: silent until both up
        BtnPlus  = 1'b0;
        BtnMinus = 1'b0;
        count_lows(40, lp, lm);
        chk("t5_both_p", lp, 0);
        chk("t5_both_m", lm, 0);
        BtnMinus = 1'b1;
        count_lows(30, lp, lm);
        chk("t5_plus_only_p", lp, 0);
        BtnPlus = 1'b1;
        count_lows(12, lp, lm);
        chk("t5_release_p", lp + lm, 0);
        BtnPlus = 1'b0;
        count_lows(8, lp, lm);
        BtnPlus = 1'b1;
        chk("t5_plus_again", lp, 1);
        count_lows(12, lp, lm);
        BtnMinus = 1'b0;
        count_lows(8, lp, lm);
        BtnMinus = 1'b1;
        chk("t5_minus_alone", {lp[7:0], lm[7:0]}, 16'h0001);
        repeat (12) step();

        // Timeout after three ticks; Blink toggles per tick
        chk("t6_pre_mode", EditMode, 1);
        tick();
        chk("t6_blink1", Blink, 1);
        repeat (4) step();
        tick();
        chk("t6_blink2", {EditMode, Blink}, 2'b10);
        repeat (4) step();
        tick();
        chk("t6_timeout", {EditMode, EditPos, Blink}, 5'b0);

        // A press landing on the expiry tick keeps EDIT
        tap(1, 8, 12);
        tick();
        repeat (2) step();
        tick();
        repeat (2) step();
        BtnPlus = 1'b0;
        repeat (5) step();
        ClkSecond = 1'b1;
        step();
        ClkSecond = 1'b0;
        chk("t6_press_wins", EditMode, 1);
        chk("t6_press_strobe", KeyPlus, 0);
        BtnPlus = 1'b1;
        repeat (12) step();
        tick();
        repeat (2) step();
        tick();
        chk("t6_restart", EditMode, 1);
        repeat (2) step();
        tick();
        chk("t6_timeout2", EditMode, 0);

        // Reset in the middle of a strobe
        tap(1, 8, 12);
        tap(1, 8, 12);
        chk("t1_pre_pos", EditPos, 1);
        chk("t1_pre_scr", screen, 1);
        BtnPlus = 1'b0;
        repeat (6) step();
        chk("t1_pre_key", KeyPlus, 0);
        #1 reset = 1'b0;
        #1;
        chk("t1_key", KeyPlus, 1);
        chk("t1_out", {EditMode, EditPos, screen, Blink}, 7'b0);
        BtnPlus = 1'b1;
        repeat (3) step();
        reset = 1'b1;

        // Random stimulus against the model
        model_reset();
        rawv = 4'b1111;
        maxr = '{15, 40, 50};
        for (int b = 0; b < 3; b++) runl[b] = $urandom_range(5, 20);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < 3; b++) begin
                if (runl[b] == 0) begin
                    rawv[b] = ~rawv[b];
                    runl[b] = $urandom_range(1, maxr[b]);
                end
                runl[b]--;
            end
            tk = ($urandom_range(0, 11) == 0);
            BtnScreen = rawv[0];
            BtnEdit   = rawv[1];
            BtnPlus   = rawv[2];
            BtnMinus  = 1'b1;
            ClkSecond = tk;
            step();
            model_edge(rawv, tk);
            act = {EditMode, EditPos, screen, KeyPlus, KeyMinus, Blink};
            exp = {medit, 3'(mpos), 2'(mscr), kp, 1'b1, mblink};
            chk($sformatf("rand_c%0d", cyc), act, exp);
        end
        ClkSecond = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
